// File: rtl/npu_out_drain.sv
// npu_out_drain: pulls byte pairs from the NPU output FIFO and
// presents them as 16-bit words with frame position tracking.
module npu_out_drain #(
  parameter int FRAME_WORDS = 4
) (
  input  logic        CLKEXT,
  input  logic        RST_GLO_N,
  input  logic        EN_DRAIN,
  input  logic        CLR_DRAIN,
  input  logic        EMPTY,
  input  logic [7:0]  FIFO_DATA,
  output logic        RD_EN,
  output logic [15:0] WORD_OUT,
  output logic        WORD_VALID,
  input  logic        WORD_READY,
  output logic [1:0]  WORD_IDX,
  output logic        FRAME_LAST,
  output logic [7:0]  FRAME_CNT,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    CAP_HI,
    RD_LO,
    CAP_LO,
    OUT
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(FRAME_WORDS - 1);

  state_t     state;
  logic [7:0] hi_byte;

  // Read strobe must follow EMPTY in the same cycle, so it is decoded
  // from state; a pending clear blocks it so no byte is lost.
  assign RD_EN = !CLR_DRAIN && !EMPTY &&
                 ((state == RD_HI && EN_DRAIN) ||
                  state == RD_LO);

  assign BUSY = (state != IDLE);

  // Drain sequencer: read high byte, read low byte, hold word.
  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) begin
      state      <= IDLE;
      hi_byte    <= '0;
      WORD_OUT   <= '0;
      WORD_VALID <= 1'b0;
      WORD_IDX   <= '0;
      FRAME_LAST <= 1'b0;
      FRAME_CNT  <= '0;
    end else if (CLR_DRAIN) begin
      state      <= IDLE;
      hi_byte    <= '0;
      WORD_OUT   <= '0;
      WORD_VALID <= 1'b0;
      WORD_IDX   <= '0;
      FRAME_LAST <= 1'b0;
      FRAME_CNT  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (EN_DRAIN) state <= RD_HI;
        end
        RD_HI: begin
          if (!EN_DRAIN) state <= IDLE;
          else if (!EMPTY) state <= CAP_HI;
        end
        CAP_HI: begin
          hi_byte <= FIFO_DATA;
          state   <= RD_LO;
        end
        RD_LO: begin
          if (!EMPTY) state <= CAP_LO;
        end
        CAP_LO: begin
          WORD_OUT   <= {hi_byte, FIFO_DATA};
          WORD_VALID <= 1'b1;
          FRAME_LAST <= (WORD_IDX == LAST_IDX);
          state      <= OUT;
        end
        OUT: begin
          if (WORD_READY) begin
            WORD_VALID <= 1'b0;
            FRAME_LAST <= 1'b0;
            if (WORD_IDX == LAST_IDX) WORD_IDX <= '0;
            else WORD_IDX <= WORD_IDX + 2'd1;
            if (FRAME_LAST) FRAME_CNT <= FRAME_CNT + 8'd1;
            state <= EN_DRAIN ? RD_HI : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_out_drain.sv
// tb_npu_out_drain: FIFO model, scoreboard of expected words and
// directed plus randomized drain scenarios.
module tb_npu_out_drain;

  localparam int FW = 4;

  logic        CLKEXT = 1'b0;
  logic        RST_GLO_N = 1'b0;
  logic        EN_DRAIN = 1'b0;
  logic        CLR_DRAIN = 1'b0;
  logic        EMPTY = 1'b1;
  logic [7:0]  FIFO_DATA = 8'h00;
  logic        RD_EN;
  logic [15:0] WORD_OUT;
  logic        WORD_VALID;
  logic        WORD_READY = 1'b0;
  logic [1:0]  WORD_IDX;
  logic        FRAME_LAST;
  logic [7:0]  FRAME_CNT;
  logic        BUSY;

  npu_out_drain #(.FRAME_WORDS(FW)) dut (
    .CLKEXT(CLKEXT),
    .RST_GLO_N(RST_GLO_N),
    .EN_DRAIN(EN_DRAIN),
    .CLR_DRAIN(CLR_DRAIN),
    .EMPTY(EMPTY),
    .FIFO_DATA(FIFO_DATA),
    .RD_EN(RD_EN),
    .WORD_OUT(WORD_OUT),
    .WORD_VALID(WORD_VALID),
    .WORD_READY(WORD_READY),
    .WORD_IDX(WORD_IDX),
    .FRAME_LAST(FRAME_LAST),
    .FRAME_CNT(FRAME_CNT),
    .BUSY(BUSY)
  );

  typedef struct {
    logic [15:0] word;
    int          idx;
    logic        last;
    int          fcnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  fifo[$];
  logic        stall = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          n_words = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          hs_cnt = 0;
  int          first_rd = -1;
  int          last_hs = -1;
  logic        hold_prev = 1'b0;
  logic [15:0] prev_word = 16'h0;

  always #5 CLKEXT = ~CLKEXT;

  always @(posedge CLKEXT) cyc++;

  // FIFO model: pop on read strobe, data visible the next cycle.
  always @(posedge CLKEXT)
    if (RST_GLO_N && RD_EN && fifo.size() > 0)
      FIFO_DATA <= fifo.pop_front();

  always @(negedge CLKEXT) begin
    #1;
    EMPTY = (fifo.size() == 0) || stall;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: word n of the stream sits at n mod FW in frame n/FW.
  task automatic expect_word(input logic [15:0] w);
    exp_t e;
    e.word = w;
    e.idx  = n_words % FW;
    e.last = (e.idx == FW - 1);
    e.fcnt = (n_words / FW) % 256;
    exp_q.push_back(e);
    n_words++;
  endtask

  task automatic push_word(input logic [7:0] hi, input logic [7:0] lo);
    fifo.push_back(hi);
    fifo.push_back(lo);
    expect_word({hi, lo});
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge CLKEXT);
      k++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge CLKEXT);
  endtask

  task automatic wait_rd_en(input int budget);
    int k = 0;
    @(negedge CLKEXT);
    #2;
    while (!RD_EN && k < budget) begin
      @(negedge CLKEXT);
      #2;
      k++;
    end
    chk("rd_en_seen", RD_EN, 1);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    @(negedge CLKEXT);
    #2;
    while (!WORD_VALID && k < budget) begin
      @(negedge CLKEXT);
      #2;
      k++;
    end
    chk("valid_seen", WORD_VALID, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, RD_EN, 0);
    chk({tag, "_word_out"}, WORD_OUT, 0);
    chk({tag, "_valid"}, WORD_VALID, 0);
    chk({tag, "_idx"}, WORD_IDX, 0);
    chk({tag, "_last"}, FRAME_LAST, 0);
    chk({tag, "_fcnt"}, FRAME_CNT, 0);
    chk({tag, "_busy"}, BUSY, 0);
  endtask

  // Monitor: protocol checks and scoreboard pops on handshakes.
  always @(negedge CLKEXT) begin
    #2;
    if (RST_GLO_N) begin
      if (RD_EN) begin
        chk("rd_en_while_empty", int'(EMPTY), 0);
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (hold_prev) begin
        chk("valid_held", WORD_VALID, 1);
        chk("word_stable", WORD_OUT, prev_word);
      end
      if (WORD_VALID && WORD_READY && !CLR_DRAIN) begin
        hs_cnt++;
        last_hs = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none",
                   WORD_OUT);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word", WORD_OUT, mon_e.word);
          chk("word_idx", WORD_IDX, mon_e.idx);
          chk("frame_last", FRAME_LAST, mon_e.last);
          chk("frame_cnt_hs", FRAME_CNT, mon_e.fcnt);
        end
      end
      hold_prev = WORD_VALID && !WORD_READY && !CLR_DRAIN;
      prev_word = WORD_OUT;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    int k;
    int rd0;
    int hs0;
    logic [7:0] b0;
    logic [7:0] b1;

    // Reset state
    repeat (3) @(negedge CLKEXT);
    chk_zero("reset");
    RST_GLO_N = 1'b1;
    @(negedge CLKEXT);
    chk("idle_after_reset", BUSY, 0);

    // Preloaded frame 0x01..0x08 at full rate
    for (int i = 1; i <= 8; i++) fifo.push_back(8'(i));
    for (int i = 0; i < 4; i++)
      expect_word({8'(2 * i + 1), 8'(2 * i + 2)});
    WORD_READY = 1'b1;
    first_rd = -1;
    @(negedge CLKEXT);
    EN_DRAIN = 1'b1;
    wait_drain(100);
    chk("frame_cycles", last_hs - first_rd + 1, 20);
    chk("frame_cnt_1", FRAME_CNT, 1);
    chk("idx_wrap_1", WORD_IDX, 0);

    // FIFO runs dry between high and low byte
    fifo.push_back(8'hAB);
    k = 0;
    while (fifo.size() != 0 && k < 50) begin
      @(negedge CLKEXT);
      k++;
    end
    rd0 = rd_cnt;
    repeat (10) @(negedge CLKEXT);
    chk("stall_no_rd", rd_cnt - rd0, 0);
    fifo.push_back(8'hCD);
    expect_word(16'hABCD);
    wait_drain(50);

    // Back-pressure for 7 cycles
    WORD_READY = 1'b0;
    push_word(8'($urandom), 8'($urandom));
    push_word(8'($urandom), 8'($urandom));
    wait_valid(50);
    rd0 = rd_cnt;
    hs0 = hs_cnt;
    repeat (7) @(negedge CLKEXT);
    chk("bp_no_rd", rd_cnt - rd0, 0);
    chk("bp_no_hs", hs_cnt - hs0, 0);
    chk("bp_valid", WORD_VALID, 1);
    WORD_READY = 1'b1;
    wait_drain(50);
    chk("bp_hs_total", hs_cnt - hs0, 2);

    // Enable drops while the high byte is captured
    push_word(8'($urandom), 8'($urandom));
    wait_rd_en(50);
    @(negedge CLKEXT);
    EN_DRAIN = 1'b0;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    fifo.push_back(b0);
    fifo.push_back(b1);
    wait_drain(50);
    rd0 = rd_cnt;
    repeat (10) @(negedge CLKEXT);
    chk("parked_no_rd", rd_cnt - rd0, 0);
    chk("parked_idle", BUSY, 0);
    expect_word({b0, b1});
    EN_DRAIN = 1'b1;
    wait_drain(50);

    // Synchronous clear with a partial frame in the counters
    chk("fcnt_before_clr", FRAME_CNT, 2);
    @(negedge CLKEXT);
    CLR_DRAIN = 1'b1;
    @(negedge CLKEXT);
    CLR_DRAIN = 1'b0;
    #1;
    chk("clr_fcnt", FRAME_CNT, 0);
    chk("clr_idx", WORD_IDX, 0);
    chk("clr_busy", BUSY, 0);
    n_words = 0;

    // 256 random frames with random ready and FIFO stalls
    for (int i = 0; i < 256 * FW; i++)
      push_word(8'($urandom), 8'($urandom));
    k = 0;
    while (exp_q.size() != 0 && k < 30000) begin
      @(negedge CLKEXT);
      WORD_READY = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 7) == 0);
      k++;
    end
    @(negedge CLKEXT);
    WORD_READY = 1'b1;
    stall = 1'b0;
    wait_drain(50);
    chk("wrap_fcnt", FRAME_CNT, 0);
    chk("wrap_idx", WORD_IDX, 0);

    // Reset while waiting to read the low byte
    for (int i = 0; i < FW; i++)
      push_word(8'($urandom), 8'($urandom));
    wait_drain(100);
    chk("fcnt_before_rst", FRAME_CNT, 1);
    fifo.push_back(8'($urandom));
    fifo.push_back(8'($urandom));
    wait_rd_en(50);
    @(negedge CLKEXT);
    @(negedge CLKEXT);
    #1;
    RST_GLO_N = 1'b0;
    #1;
    chk_zero("async_rst");
    fifo.delete();
    exp_q.delete();
    n_words = 0;
    @(negedge CLKEXT);
    RST_GLO_N = 1'b1;
    push_word(8'($urandom), 8'($urandom));
    wait_drain(50);
    chk("resume_idx", WORD_IDX, 1);

    // Clear coincident with the last-word handshake
    for (int i = 0; i < 3; i++)
      push_word(8'($urandom), 8'($urandom));
    wait_drain(100);
    chk("fcnt_pre_clr_hs", FRAME_CNT, 1);
    for (int i = 0; i < 3; i++)
      push_word(8'($urandom), 8'($urandom));
    wait_drain(100);
    WORD_READY = 1'b0;
    push_word(8'($urandom), 8'($urandom));
    wait_valid(50);
    chk("pending_last", FRAME_LAST, 1);
    @(negedge CLKEXT);
    WORD_READY = 1'b1;
    CLR_DRAIN = 1'b1;
    exp_q.delete();
    @(negedge CLKEXT);
    CLR_DRAIN = 1'b0;
    #1;
    chk_zero("clr_hs");

    repeat (3) @(negedge CLKEXT);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_out_drain.md
NPU_OUT_DRAIN -- requirements
Module: npu_out_drain

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 4: number of 16-bit words in one inference frame.
REQ-002 SHALL have port CLKEXT, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_GLO_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port EN_DRAIN, input, 1 bit: permits new FIFO reads.
REQ-005 SHALL have port CLR_DRAIN, input, 1 bit: synchronous clear of FSM and counters.
REQ-006 SHALL have port EMPTY, input, 1 bit: output-FIFO empty flag.
REQ-007 SHALL have port FIFO_DATA, input, 8 bits: output-FIFO read data, valid the cycle after RD_EN.
REQ-008 SHALL have port RD_EN, output, 1 bit: single-cycle FIFO read strobe.
REQ-009 SHALL have port WORD_OUT, output, 16 bits: assembled word {high byte, low byte}.
REQ-010 SHALL have port WORD_VALID, output, 1 bit: WORD_OUT is valid.
REQ-011 SHALL have port WORD_READY, input, 1 bit: downstream accepts the word.
REQ-012 SHALL have port WORD_IDX, output, 2 bits: position of the word within its frame (0 = first word, which is the neuron-4 result).
REQ-013 SHALL have port FRAME_LAST, output, 1 bit: high with WORD_VALID when WORD_IDX == FRAME_WORDS-1.
REQ-014 SHALL have port FRAME_CNT, output, 8 bits: count of completed frames.
REQ-015 SHALL have port BUSY, output, 1 bit: FSM is not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, RD_HI, CAP_HI, RD_LO, CAP_LO, OUT.
REQ-017 IDLE SHALL go to RD_HI when EN_DRAIN=1; otherwise it stays in IDLE.
REQ-018 RD_HI SHALL assert RD_EN for exactly one cycle when EMPTY=0 and EN_DRAIN=1, then go to CAP_HI.
REQ-019 RD_HI SHALL wait with RD_EN=0 while EMPTY=1, and SHALL return to IDLE if EN_DRAIN=0.
REQ-020 CAP_HI SHALL register FIFO_DATA as the high byte, then go to RD_LO.
REQ-021 RD_LO SHALL assert RD_EN for one cycle when EMPTY=0 (EN_DRAIN ignored), then go to CAP_LO.
REQ-022 RD_LO SHALL wait, holding the high byte, while EMPTY=1.
REQ-023 CAP_LO SHALL register FIFO_DATA as the low byte, load WORD_OUT, and go to OUT.
REQ-024 OUT SHALL hold WORD_VALID=1 with WORD_OUT, WORD_IDX and FRAME_LAST stable until the cycle in which WORD_READY=1.
REQ-025 On that handshake, OUT SHALL go to RD_HI if EN_DRAIN=1, else to IDLE.
REQ-026 RD_EN SHALL never assert while EMPTY=1, and SHALL never assert in CAP_HI, CAP_LO or OUT.
REQ-027 Minimum throughput SHALL be one word per 5 cycles (RD_HI, CAP_HI, RD_LO, CAP_LO, OUT with WORD_READY already high).
REQ-028 Latency SHALL be: WORD_VALID rises 2 cycles after the second RD_EN pulse.
REQ-029 WORD_IDX SHALL increment on each handshake and wrap from FRAME_WORDS-1 to 0.
REQ-030 FRAME_CNT SHALL increment on the handshake where FRAME_LAST=1, and wrap 255->0.
REQ-031 EN_DRAIN falling mid-word SHALL NOT abort the word: the word completes and the FSM then parks in IDLE.
REQ-032 CLR_DRAIN=1 SHALL force IDLE at the next edge, with WORD_VALID=0, WORD_IDX=0, FRAME_CNT=0 and the byte registers cleared.
REQ-033 Any byte being captured in the cycle CLR_DRAIN=1 SHALL be discarded.
REQ-034 CLR_DRAIN SHALL have priority over all other inputs, including a simultaneous WORD_READY handshake (no FRAME_CNT increment).
REQ-035 BUSY SHALL equal (state != IDLE).

Reset
REQ-036 RST_GLO_N=0 SHALL immediately, without a clock edge, force the FSM to IDLE and all outputs to zero: RD_EN, WORD_OUT, WORD_VALID, WORD_IDX, FRAME_LAST, FRAME_CNT and BUSY.
REQ-037 Assertion of reset mid-word SHALL discard partial bytes.
REQ-038 After reset deassertion the block SHALL resume from IDLE with WORD_IDX=0.

Verification
REQ-039 SHALL cover this scenario: FIFO preloaded with 8 bytes 0x01..0x08, EN_DRAIN=1, WORD_READY=1 -> words 0x0102, 0x0304, 0x0506, 0x0708 with WORD_IDX 0..3; FRAME_LAST only on 0x0708; FRAME_CNT 0->1; 20 cycles from first RD_EN to the last handshake.
REQ-040 SHALL cover this scenario: EMPTY asserted after the high byte 0xAB, deasserted 10 cycles later with 0xCD -> no RD_EN during the stall; single word 0xABCD.
REQ-041 SHALL cover this scenario: WORD_READY held low for 7 cycles while a word is pending -> WORD_VALID stays high, WORD_OUT stable, no RD_EN; exactly one handshake.
REQ-042 SHALL cover this scenario: EN_DRAIN dropped in CAP_HI -> the word completes; the FSM then reaches IDLE; no further RD_EN until EN_DRAIN=1.
REQ-043 SHALL cover this scenario: 256 full frames drained -> FRAME_CNT wraps to 0; WORD_IDX back at 0.
REQ-044 SHALL cover this scenario: RST_GLO_N pulsed low in RD_LO, and separately CLR_DRAIN coincident with a handshake -> all outputs 0 immediately (reset) or at the next edge (clear); FRAME_CNT not incremented.
